// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end: coin codes seen by the
// vending FSM and the one-hot state encoding of the coin acceptor.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_05   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EMIT = 3'b010,
        HOLD = 3'b100
    } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: two-flop synchroniser, counter debounce and a
// one-cycle pulse on every rising edge of the debounced level.
module coin_debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic sns_i,
    output logic rise_o
);

    // The level flips on the DEB_CYC-th consecutive differing sample.
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       rise_q;
    logic [3:0] cnt_q;

    // Two flops bring the asynchronous sensor into the clk domain.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sns_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing samples; flip the level after DEB_CYC in a row and flag a rise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
                rise_q  <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces both sensors, classifies each insertion
// (accept / reject / error) and hands accepted coins to the vending FSM as
// single-cycle codes separated by at least GAP_CYC idle cycles.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sns_05,
    input  logic       sns_10,
    input  logic       en,
    output logic [1:0] coin,
    output logic       rej,
    output logic       coin_err
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC);

    // Bit 0 is the 0.5-yuan channel, bit 1 the 1-yuan channel.
    logic [1:0] sns_raw;
    logic [1:0] rise;

    logic [1:0] acc;
    logic [1:0] avail;
    logic       try_emit;

    acc_state_e state_q, state_d;
    logic [1:0] coin_q, coin_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] pend_q, pend_d;
    logic       rej_q, rej_d;
    logic       err_q, err_d;

    assign sns_raw = {sns_10, sns_05};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            coin_debounce #(
                .DEB_CYC(DEB_CYC)
            ) u_deb (
                .clk   (clk),
                .rstn  (rstn),
                .sns_i (sns_raw[gi]),
                .rise_o(rise[gi])
            );
        end
    endgenerate

    // Decide the fate of this cycle's insertions: reject, flag an error, or accept.
    always_comb begin
        acc   = 2'b00;
        rej_d = 1'b0;
        err_d = 1'b0;
        if (rise != 2'b00) begin
            if (!en) begin
                rej_d = 1'b1;
            end else if (rise == 2'b11) begin
                rej_d = 1'b1;
                err_d = 1'b1;
            end else if ((rise & pend_q) != 2'b00) begin
                // Already one of this denomination waiting: keep it, bounce the new one.
                rej_d = 1'b1;
                err_d = 1'b1;
            end else begin
                acc = rise;
            end
        end
    end

    // Emit scheduler: a coin accepted this cycle may be emitted straight away from IDLE.
    always_comb begin
        avail    = pend_q | acc;
        state_d  = state_q;
        coin_d   = COIN_NONE;
        gap_d    = gap_q;
        pend_d   = avail;
        try_emit = 1'b0;
        case (state_q)
            IDLE: try_emit = 1'b1;
            EMIT: begin
                gap_d   = GAP_LOAD;
                state_d = HOLD;
            end
            HOLD: begin
                if (gap_q <= 4'd1) begin
                    // Last idle cycle of the gap: the next code may follow immediately.
                    gap_d    = '0;
                    state_d  = IDLE;
                    try_emit = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (try_emit) begin
            if (avail[0]) begin
                coin_d    = COIN_05;
                pend_d[0] = 1'b0;
                state_d   = EMIT;
            end else if (avail[1]) begin
                coin_d    = COIN_10;
                pend_d[1] = 1'b0;
                state_d   = EMIT;
            end
        end
    end

    // State, pending coins and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            coin_q  <= COIN_NONE;
            gap_q   <= '0;
            pend_q  <= 2'b00;
            rej_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            rej_q   <= rej_d;
            err_q   <= err_d;
        end
    end

    assign coin     = coin_q;
    assign rej      = rej_q;
    assign coin_err = err_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, hand-written corner
// sequences and randomized sensor traffic against a behavioural model.
module tb_coin_acceptor;
    import vend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, en, sns_05, sns_10;
    logic       en_b, sns05_b, sns10_b;
    logic [1:0] coin, coin_b;
    logic       rej, coin_err, rej_b, coin_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    coin_acceptor #(.DEB_CYC(4), .GAP_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .sns_05(sns_05), .sns_10(sns_10), .en(en),
        .coin(coin), .rej(rej), .coin_err(coin_err)
    );

    // Slow-gap instance so one channel can overflow within a single gap.
    coin_acceptor #(.DEB_CYC(2), .GAP_CYC(15)) dut_b (
        .clk(clk), .rstn(rstn), .sns_05(sns05_b), .sns_10(sns10_b), .en(en_b),
        .coin(coin_b), .rej(rej_b), .coin_err(coin_err_b)
    );

    // Reference model: sensor delay line, window debounce, pending set, time since last code.
    typedef struct {
        logic [1:0]       s1, s2, lvl, rise, pend;
        logic [1:0][15:0] hist;
        int               since_emit;
        logic [1:0]       coin;
        logic             rej, err;
    } model_t;

    model_t mdl_a, mdl_b;

    function automatic model_t model_step(input model_t m, input int deb, input int gap,
                                          input logic rst_n, input logic en_v,
                                          input logic r05, input logic r10);
        model_t     n;
        logic [1:0] acc;
        logic [1:0] avail;
        logic [15:0] mask, win;
        n      = m;
        acc    = 2'b00;
        n.coin = COIN_NONE;
        n.rej  = 1'b0;
        n.err  = 1'b0;
        n.rise = 2'b00;
        if (!rst_n) begin
            n.s1 = 2'b00; n.s2 = 2'b00; n.lvl = 2'b00; n.pend = 2'b00;
            n.hist = '0;
            n.since_emit = 1000;
            return n;
        end
        if (m.rise != 2'b00) begin
            if (!en_v) n.rej = 1'b1;
            else if (m.rise == 2'b11) begin n.rej = 1'b1; n.err = 1'b1; end
            else if ((m.rise & m.pend) != 2'b00) begin n.rej = 1'b1; n.err = 1'b1; end
            else acc = m.rise;
        end
        avail  = m.pend | acc;
        n.pend = avail;
        n.since_emit = (m.since_emit < 1000) ? m.since_emit + 1 : 1000;
        if (n.since_emit >= gap + 1) begin
            if (avail[0]) begin n.coin = COIN_05; n.pend[0] = 1'b0; n.since_emit = 0; end
            else if (avail[1]) begin n.coin = COIN_10; n.pend[1] = 1'b0; n.since_emit = 0; end
        end
        mask = 16'((32'd1 << deb) - 1);
        for (int i = 0; i < 2; i++) begin
            n.hist[i] = {m.hist[i][14:0], m.s2[i]};
            win = n.hist[i] & mask;
            if (!m.lvl[i] && win == mask) begin n.lvl[i] = 1'b1; n.rise[i] = 1'b1; end
            else if (m.lvl[i] && win == 16'd0) n.lvl[i] = 1'b0;
        end
        n.s2 = m.s1;
        n.s1 = {r10, r05};
        return n;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {coin,rej,err} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance both models with the inputs the DUTs see, compare at negedge.
    task automatic tick();
        @(posedge clk);
        mdl_a = model_step(mdl_a, 4, 2, rstn, en, sns_05, sns_10);
        mdl_b = model_step(mdl_b, 2, 15, rstn, en_b, sns05_b, sns10_b);
        @(negedge clk);
        check("model_a", {coin, rej, coin_err}, {mdl_a.coin, mdl_a.rej, mdl_a.err});
        check("model_b", {coin_b, rej_b, coin_err_b}, {mdl_b.coin, mdl_b.rej, mdl_b.err});
    endtask

    task automatic settle(input int n);
        sns_05 = 1'b0; sns_10 = 1'b0; en = 1'b1;
        sns05_b = 1'b0; sns10_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        string name;
        int s05_on, s05_len, s10_on, s10_len, en_off, n_ticks;
        int t05, t10, t_rej, t_err;
    } vec_t;

    vec_t vecs[7];

    int hold_a[2], hold_b[2];

    initial begin
        // Stimulus table: sensor windows in ticks, expected tick of each output pulse (-1 none).
        vecs[0] = '{"single_10",     0, 0,  1, 20, 99, 25, -1,  7, -1, -1};
        vecs[1] = '{"glitch_05",     1, 3,  0,  0, 99, 15, -1, -1, -1, -1};
        vecs[2] = '{"deb_exact_05",  1, 4,  0,  0, 99, 15,  7, -1, -1, -1};
        vecs[3] = '{"back_to_back",  1, 20, 2, 20, 99, 25,  7, 10, -1, -1};
        vecs[4] = '{"collision",     1, 20, 1, 20, 99, 25, -1, -1,  7,  7};
        vecs[5] = '{"disabled_10",   0, 0,  1, 20,  0, 25, -1, -1,  7, -1};
        vecs[6] = '{"en_drop_keep",  1, 20, 2, 20,  9, 25,  7, 10, -1, -1};

        rstn = 1'b0; en = 1'b1; sns_05 = 1'b1; sns_10 = 1'b1;
        en_b = 1'b1; sns05_b = 1'b0; sns10_b = 1'b0;

        // Reset held with sensors high: outputs stay quiet.
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("reset_quiet", {coin, rej, coin_err}, 4'b0000);
        end
        // Released with sensors still high: both debounce together and collide.
        rstn = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("post_reset", {coin, rej, coin_err}, (t == 7) ? 4'b0011 : 4'b0000);
        end
        settle(20);

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            for (int t = 1; t <= vecs[v].n_ticks; t++) begin
                sns_05 = (t >= vecs[v].s05_on) && (t < vecs[v].s05_on + vecs[v].s05_len);
                sns_10 = (t >= vecs[v].s10_on) && (t < vecs[v].s10_on + vecs[v].s10_len);
                en     = (t < vecs[v].en_off);
                tick();
                check(vecs[v].name, {coin, rej, coin_err},
                      {(t == vecs[v].t05) ? COIN_05 : (t == vecs[v].t10) ? COIN_10 : COIN_NONE,
                       t == vecs[v].t_rej, t == vecs[v].t_err});
            end
            settle(20);
        end

        // Reset while a 1-yuan coin is pending: it vanishes without a reject.
        for (int t = 1; t <= 22; t++) begin
            sns_05 = (t <= 8);
            sns_10 = (t >= 2) && (t <= 8);
            rstn   = (t != 9);
            tick();
            check("reset_drop", {coin, rej, coin_err}, (t == 7) ? 4'b0100 : 4'b0000);
        end
        rstn = 1'b1;
        settle(10);

        // Overflow on the slow-gap instance: three 0.5 coins during one gap.
        for (int t = 1; t <= 30; t++) begin
            sns05_b = (((t - 1) % 6) < 3) && (t <= 18);
            tick();
            check("overflow_05", {coin_b, rej_b, coin_err_b},
                  {(t == 5 || t == 21) ? COIN_05 : COIN_NONE, t == 17, t == 17});
        end
        settle(20);

        // Randomized sensor traffic, enable toggling and occasional resets.
        hold_a = '{0, 0};
        hold_b = '{0, 0};
        for (int c = 0; c < 4000; c++) begin
            if (hold_a[0] == 0) begin sns_05  = 1'($urandom_range(0, 1)); hold_a[0] = $urandom_range(1, 10); end
            if (hold_a[1] == 0) begin sns_10  = 1'($urandom_range(0, 1)); hold_a[1] = $urandom_range(1, 10); end
            if (hold_b[0] == 0) begin sns05_b = 1'($urandom_range(0, 1)); hold_b[0] = $urandom_range(1, 6); end
            if (hold_b[1] == 0) begin sns10_b = 1'($urandom_range(0, 1)); hold_b[1] = $urandom_range(1, 6); end
            for (int i = 0; i < 2; i++) begin hold_a[i]--; hold_b[i]--; end
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) en_b = ~en_b;
            rstn = ($urandom_range(0, 499) != 0);
            tick();
        end
        rstn = 1'b1;
        settle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage feeding the vending FSM's coin[1:0] input.
- Synchronises and debounces two raw coin-slot sensors (0.5 yuan, 1 yuan).
- Converts each accepted insertion into exactly one single-cycle coin code (01 = 0.5, 10 = 1.0), with a guaranteed idle gap between codes.
- Rejects coins when disabled, on collision, or on pending overflow.

Parameters:
- DEB_CYC, 4: consecutive stable synchronised samples required to change a debounced level (range 2..15).
- GAP_CYC, 2: minimum cycles of coin = 00 after every emitted code (range 1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- sns_05  in  1  raw 0.5-yuan sensor, asynchronous, high = coin present
- sns_10  in  1  raw 1-yuan sensor, asynchronous, high = coin present
- en  in  1  1 = accepting coins; 0 = every new coin is rejected
- coin  out  2  one-cycle coin code to the vending FSM; 00 when idle
- rej  out  1  one-cycle pulse: coin diverted to the return chute
- coin_err  out  1  one-cycle pulse: collision or pending overflow

Behaviour:
- Reset: rstn is sampled on posedge clk.
  - coin = 00, rej = 0, coin_err = 0.
  - Sync flops, debounced levels, counters, pending bits and FSM all clear; FSM = IDLE.
  - Reset mid-operation drops any pending coin silently (no rej pulse).
- Synchroniser: two flops per sensor.
- Debounce, per channel:
  - Counter increments while the sync output differs from the debounced level; it clears when they match.
  - When the counter reaches DEB_CYC, the debounced level toggles and the counter clears.
  - A glitch shorter than DEB_CYC cycles never toggles the level.
- Event: a rising edge of a debounced level, one cycle wide. Falling edges are ignored.
- Latency: raw sensor high and held from edge E → coin valid in the cycle after edge E+DEB_CYC+2. Total is DEB_CYC+3 edges (7 at default).
- Event classification, same cycle as the event:
  - en = 0: rej pulse. No coin, not queued.
  - Both channels in the same cycle: coin_err and rej pulse. Both coins are dropped.
  - Otherwise the event sets the pending bit for its denomination.
  - If that pending bit is already set: coin_err and rej pulse, and the existing pending bit is kept.
- FSM, registered outputs:
  - IDLE: if pend_05, emit 01 and clear pend_05 → EMIT. Else if pend_10, emit 10 and clear pend_10 → EMIT. Else stay, coin = 00.
  - EMIT: coin held for exactly one cycle; load gap counter with GAP_CYC → HOLD.
  - HOLD: coin = 00; decrement the counter. At 0 → IDLE, and pending is examined that same cycle. Events during HOLD only set pending.
- Priority: 0.5 before 1.0 when both are pending.
- Consecutive codes are always separated by ≥ GAP_CYC zero cycles.
- Pulses on a new event are still classified while en toggles.
- en falling does not flush pending: already accepted coins are still emitted.
- Width rules: debounce counter 4 bits, gap counter 4 bits; no wrap is possible within the parameter ranges.
- rej and coin_err are registered, one cycle after the event, never stretched.

Decomposition:
- Shared package (vend_pkg):
  - Coin codes COIN_NONE = 2'b00, COIN_05 = 2'b01, COIN_10 = 2'b10; these are also used by the vending FSM.
  - FSM state encoding IDLE/EMIT/HOLD, one-hot 3-bit.
- Sub-module coin_debounce (sync + debounce + rising-edge detect, parameter DEB_CYC), instantiated once per sensor.

Test Plan:
- Reset: drive rstn = 0 for 3 cycles with both sensors high → coin = 00, rej = 0, coin_err = 0 throughout; after release, the held-high sensors produce no events until debounced.
- Single coin: en = 1, sns_10 high at edge 10 held 20 cycles, DEB_CYC = 4 → coin = 10 for exactly the cycle after edge 16, then 00; no rej.
- Glitch: sns_05 high for 3 cycles, then low → coin stays 00, rej = 0.
- Back-to-back: sns_05 event, then sns_10 event 1 cycle later → coin = 01, then 00 for GAP_CYC = 2 cycles, then 10.
- Collision: both sensors rise at the same edge → one cycle of coin_err = 1 and rej = 1; coin stays 00.
- Disabled/overflow:
  - en = 0, sns_10 event → rej = 1 for one cycle, coin 00.
  - en = 1, three sns_05 events inside one HOLD window → the 2nd is queued; the 3rd gives coin_err = 1, rej = 1; total of exactly two 01 codes emitted.
